// File: rtl/mul_div_unit_if.sv
// Request, MTHI/MTLO and result signals of the multiply/divide unit.
interface mul_div_unit_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        hi_we_i;
  logic        lo_we_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic        div_zero_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport slave (
    input  start_i, op_i, src1_i, src2_i, hi_we_i, lo_we_i, wdata_i,
    output busy_o, done_o, div_zero_o, hi_o, lo_o
  );

  modport master (
    output start_i, op_i, src1_i, src2_i, hi_we_i, lo_we_i, wdata_i,
    input  busy_o, done_o, div_zero_o, hi_o, lo_o
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO registers.
// Signed operands are reduced to magnitudes, iterated for 32 cycles
// (shift-add or restoring shift-subtract), then sign-corrected in FIX.
module mul_div_unit (
  input logic            clk_i,
  input logic            rst_i,
  mul_div_unit_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q,   state_d;
  logic [4:0]  cnt_q,     cnt_d;
  logic        is_div_q,  is_div_d;
  logic        neg_q_q,   neg_q_d;    // negate product / quotient in FIX
  logic        neg_r_q,   neg_r_d;    // negate remainder in FIX
  logic        dz_q,      dz_d;
  logic [31:0] divisor_q, divisor_d;  // magnitude of src2 (multiplier or divisor)
  logic [31:0] work_hi_q, work_hi_d;
  logic [31:0] work_lo_q, work_lo_d;
  logic [31:0] hi_q,      hi_d;
  logic [31:0] lo_q,      lo_d;

  logic        accept;
  logic        in_is_div;
  logic        in_signed;
  logic        src1_neg;
  logic        src2_neg;
  logic [31:0] src1_mag;
  logic [31:0] src2_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] prod;
  logic [63:0] prod_fix;

  // Operand decode and the per-iteration arithmetic shared by RUN and FIX
  always_comb begin
    accept    = bus.start_i && ((state_q == IDLE) || (state_q == DONE));
    in_is_div = bus.op_i[1];
    in_signed = ~bus.op_i[0];
    src1_neg  = in_signed & bus.src1_i[31];
    src2_neg  = in_signed & bus.src2_i[31];
    src1_mag  = src1_neg ? (~bus.src1_i + 32'd1) : bus.src1_i;
    src2_mag  = src2_neg ? (~bus.src2_i + 32'd1) : bus.src2_i;

    mul_sum   = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? divisor_q : 32'd0)};
    div_shift = {work_hi_q, work_lo_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, divisor_q};

    prod      = {work_hi_q, work_lo_q};
    prod_fix  = neg_q_q ? (~prod + 64'd1) : prod;
  end

  // Next-state, datapath and HI/LO update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    dz_d      = 1'b0;
    divisor_d = divisor_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.hi_we_i) hi_d = bus.wdata_i;
        if (bus.lo_we_i) lo_d = bus.wdata_i;
        if (accept) begin
          // Divide by zero skips the iteration entirely; its result
          // overrides any MTHI/MTLO write on the same edge.
          if (in_is_div && (bus.src2_i == 32'd0)) begin
            state_d = DONE;
            hi_d    = bus.src1_i;
            lo_d    = '1;
            dz_d    = 1'b1;
          end else begin
            state_d   = RUN;
            cnt_d     = '0;
            is_div_d  = in_is_div;
            neg_q_d   = src1_neg ^ src2_neg;
            neg_r_d   = src1_neg;
            divisor_d = src2_mag;
            work_hi_d = '0;
            work_lo_d = src1_mag;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
        if (is_div_q) begin
          if (!div_diff[33]) begin
            work_hi_d = div_diff[31:0];
            work_lo_d = {work_lo_q[30:0], 1'b1};
          end else begin
            work_hi_d = div_shift[31:0];
            work_lo_d = {work_lo_q[30:0], 1'b0};
          end
        end else begin
          {work_hi_d, work_lo_d} = {mul_sum, work_lo_q[31:1]};
        end
      end
      FIX: begin
        state_d = DONE;
        if (is_div_q) begin
          lo_d = neg_q_q ? (~work_lo_q + 32'd1) : work_lo_q;
          hi_d = neg_r_q ? (~work_hi_q + 32'd1) : work_hi_q;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dz_q      <= 1'b0;
      divisor_q <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      dz_q      <= dz_d;
      divisor_q <= divisor_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy_o     = (state_q == RUN) || (state_q == FIX);
  assign bus.done_o     = (state_q == DONE);
  assign bus.div_zero_o = dz_q;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, corner sequences
// and random operations against an arithmetic reference model.
module tb_mul_div_unit;

  logic clk;
  logic rst;

  mul_div_unit_if bus();

  mul_div_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int failed;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: {dz, hi, lo} from plain integer arithmetic
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'd0: begin p = sa * sb; return {1'b0, p}; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'd2: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        uq = a / b;
        ur = a % b;
        return {1'b0, ur, uq};
      end
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive a start for one edge (inputs change #1 after an edge)
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src1_i  = a;
    bus.src2_i  = b;
    tick();
    bus.start_i = 1'b0;
    bus.src1_i  = $urandom;
    bus.src2_i  = $urandom;
  endtask

  // Called right after the accepting edge; lat counts edges until done_o
  task automatic wait_done(output int lat, output int busy_cnt, output bit held,
                           output bit dz_clean);
    logic [31:0] h0, l0;
    h0 = bus.hi_o;
    l0 = bus.lo_o;
    lat = 0;
    busy_cnt = 0;
    held = 1'b1;
    dz_clean = 1'b1;
    while (!bus.done_o && lat < 60) begin
      if (bus.busy_o) busy_cnt++;
      if (bus.hi_o !== h0 || bus.lo_o !== l0) held = 1'b0;
      if (bus.div_zero_o !== 1'b0) dz_clean = 1'b0;
      tick();
      lat++;
    end
  endtask

  // Full operation with all result and timing checks; leaves bench in DONE cycle
  task automatic run_check(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_dz, input bit post);
    int lat, bc;
    bit held, dzc;
    start_op(op, a, b);
    wait_done(lat, bc, held, dzc);
    chk({name, ".latency"}, 64'(lat), exp_dz ? 64'd0 : 64'd33);
    chk({name, ".busy_cycles"}, 64'(bc), exp_dz ? 64'd0 : 64'd33);
    chk({name, ".hold"}, 64'(held), 64'd1);
    chk({name, ".dz_quiet"}, 64'(dzc), 64'd1);
    chk({name, ".hi"}, 64'(bus.hi_o), 64'(exp_hi));
    chk({name, ".lo"}, 64'(bus.lo_o), 64'(exp_lo));
    chk({name, ".div_zero"}, 64'(bus.div_zero_o), 64'(exp_dz));
    chk({name, ".busy_in_done"}, 64'(bus.busy_o), 64'd0);
    if (post) begin
      tick();
      chk({name, ".done_pulse"}, 64'(bus.done_o), 64'd0);
      chk({name, ".dz_after"}, 64'(bus.div_zero_o), 64'd0);
    end
  endtask

  initial begin
    logic [64:0] m;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int lat, bc, dones;
    bit held, dzc;

    tests = 0;
    failed = 0;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i = 2'd0;
    bus.src1_i = '0;
    bus.src2_i = '0;
    bus.hi_we_i = 1'b0;
    bus.lo_we_i = 1'b0;
    bus.wdata_i = '0;

    vecs[0]  = '{2'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'd3, 32'd100,        32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{2'd1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[6]  = '{2'd2, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0};
    vecs[7]  = '{2'd3, 32'hFFFF_FFFF,  32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[8]  = '{2'd0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[9]  = '{2'd2, 32'd5,          32'hFFFF_FFFD, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{2'd2, 32'h8000_0000,  32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{2'd3, 32'd1000,       32'd33,        32'd10,        32'd30,        1'b0};

    // Reset state, with reset winning over a start and writes
    tick();
    bus.start_i = 1'b1; bus.op_i = 2'd1; bus.src1_i = 32'd3; bus.src2_i = 32'd4;
    bus.hi_we_i = 1'b1; bus.lo_we_i = 1'b1; bus.wdata_i = 32'hCAFE_F00D;
    tick();
    bus.start_i = 1'b0; bus.hi_we_i = 1'b0; bus.lo_we_i = 1'b0;
    rst = 1'b0;
    chk("reset.busy", 64'(bus.busy_o), 64'd0);
    chk("reset.done", 64'(bus.done_o), 64'd0);
    chk("reset.dz", 64'(bus.div_zero_o), 64'd0);
    chk("reset.hi", 64'(bus.hi_o), 64'd0);
    chk("reset.lo", 64'(bus.lo_o), 64'd0);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      m = model(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d.model", i), m, {vecs[i].dz, vecs[i].hi, vecs[i].lo});
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b1);
    end

    // Back-to-back: second start in the DONE cycle
    run_check("b2b_first", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
    start_op(2'd0, 32'd7, 32'hFFFF_FFFD);
    chk("b2b.done_drop", 64'(bus.done_o), 64'd0);
    chk("b2b.busy", 64'(bus.busy_o), 64'd1);
    wait_done(lat, bc, held, dzc);
    chk("b2b.latency", 64'(lat), 64'd33);
    chk("b2b.result", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
    tick();

    // Start ignored while running
    start_op(2'd1, 32'd6, 32'd7);
    repeat (5) tick();
    start_op(2'd3, 32'd50, 32'd0);
    wait_done(lat, bc, held, dzc);
    chk("ignore.latency", 64'(lat + 6), 64'd33);
    chk("ignore.result", {bus.hi_o, bus.lo_o}, 64'd42);
    chk("ignore.dz", 64'(bus.div_zero_o), 64'd0);
    tick();

    // MTHI in IDLE, then both writes together
    bus.hi_we_i = 1'b1; bus.wdata_i = 32'h1234_5678;
    tick();
    bus.hi_we_i = 1'b0;
    chk("mthi.idle", {bus.hi_o, bus.lo_o}, {32'h1234_5678, 32'd42});
    bus.hi_we_i = 1'b1; bus.lo_we_i = 1'b1; bus.wdata_i = 32'hAABB_CCDD;
    tick();
    bus.hi_we_i = 1'b0; bus.lo_we_i = 1'b0;
    chk("mthilo.both", {bus.hi_o, bus.lo_o}, {32'hAABB_CCDD, 32'hAABB_CCDD});

    // Write during RUN is ignored
    start_op(2'd1, 32'd3, 32'd5);
    repeat (3) tick();
    bus.hi_we_i = 1'b1; bus.wdata_i = 32'h1234_5678;
    tick();
    bus.hi_we_i = 1'b0;
    chk("mthi.run", 64'(bus.hi_o), 64'(32'hAABB_CCDD));
    wait_done(lat, bc, held, dzc);
    chk("mthi.run_result", {bus.hi_o, bus.lo_o}, 64'd15);

    // Write in the DONE cycle takes effect
    bus.hi_we_i = 1'b1; bus.wdata_i = 32'h99;
    tick();
    bus.hi_we_i = 1'b0;
    chk("mthi.done", {bus.hi_o, bus.lo_o}, {32'h99, 32'd15});

    // Write together with an accepted start, later overwritten
    bus.hi_we_i = 1'b1; bus.wdata_i = 32'h55;
    start_op(2'd1, 32'd2, 32'd3);
    bus.hi_we_i = 1'b0;
    chk("mthi.with_start", 64'(bus.hi_o), 64'h55);
    wait_done(lat, bc, held, dzc);
    chk("mthi.with_start_result", {bus.hi_o, bus.lo_o}, 64'd6);
    tick();

    // Write on the DONE-entry edge of a divide by zero loses
    bus.lo_we_i = 1'b1; bus.hi_we_i = 1'b1; bus.wdata_i = 32'h77;
    start_op(2'd3, 32'd9, 32'd0);
    bus.lo_we_i = 1'b0; bus.hi_we_i = 1'b0;
    chk("mtlo.dz_loses", {bus.hi_o, bus.lo_o}, {32'd9, 32'hFFFF_FFFF});
    chk("mtlo.dz_flag", 64'(bus.div_zero_o), 64'd1);
    tick();

    // Reset at RUN iteration 10
    start_op(2'd1, 32'hFFFF_FFFF, 32'd3);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid.busy", 64'(bus.busy_o), 64'd0);
    chk("rst_mid.hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done_o) dones++;
      tick();
    end
    chk("rst_mid.no_done", 64'(dones), 64'd0);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      m = model(rop, ra, rb);
      run_check($sformatf("rand%0d", i), rop, ra, rb, m[63:32], m[31:0], m[64], 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, limit 2000000 required");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high, and the ports are named clk_i and rst_i.
REQ-002 clk_i  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 start_i  input  1  request to begin an operation; one cycle is sufficient.
REQ-005 op_i  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 src1_i  input  32  multiplicand or dividend (rs).
REQ-007 src2_i  input  32  multiplier or divisor (rt).
REQ-008 hi_we_i  input  1  MTHI write enable.
REQ-009 lo_we_i  input  1  MTLO write enable.
REQ-010 wdata_i  input  32  MTHI/MTLO write data.
REQ-011 busy_o  output  1  operation in progress; the pipeline stalls on this signal.
REQ-012 done_o  output  1  one-cycle completion pulse.
REQ-013 div_zero_o  output  1  completed operation was a divide by zero; valid while done_o=1.
REQ-014 hi_o  output  32  HI register.
REQ-015 lo_o  output  32  LO register.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, FIX and DONE.
REQ-017 start_i SHALL be accepted only in IDLE or DONE; when accepted, src1_i, src2_i and op_i SHALL be latched on the accepting edge.
REQ-018 start_i SHALL be ignored in RUN and FIX.
REQ-019 On acceptance, the FSM SHALL enter RUN with the iteration counter at 0.
REQ-020 RUN SHALL last exactly 32 cycles, one iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-021 After RUN, the FSM SHALL move to FIX for 1 cycle (sign correction), then to DONE for 1 cycle, then to IDLE (or to RUN if a start is accepted in DONE).
REQ-022 Latency: with the accepting edge as edge 0, done_o SHALL be 1 for exactly the cycle following edge 33.
REQ-023 busy_o SHALL be 1 in RUN and FIX and 0 in IDLE and DONE.
REQ-024 done_o SHALL be 1 only in DONE.
REQ-025 hi_o and lo_o SHALL be updated on the edge entering DONE and SHALL hold that value until the next completion or MTHI/MTLO write; no intermediate values SHALL be visible on hi_o or lo_o.
REQ-026 MULT/MULTU: {hi_o, lo_o} SHALL equal the full 64-bit product, signed or unsigned respectively.
REQ-027 Signed operations SHALL be computed on magnitudes, with the sign applied in FIX.
REQ-028 DIV/DIVU: lo_o SHALL be the quotient, truncated toward zero; hi_o SHALL be the remainder, carrying the sign of the dividend.
REQ-029 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo_o=0x80000000 and hi_o=0, with no exception.
REQ-030 Divide by zero (DIV/DIVU with src2_i=0 at acceptance): the FSM SHALL go directly from acceptance to DONE, so done_o=1 in the cycle after edge 0.
REQ-031 In that divide-by-zero case: lo_o=0xFFFFFFFF, hi_o=the latched src1_i, div_zero_o=1.
REQ-032 div_zero_o SHALL be 0 in every other cycle.
REQ-033 hi_we_i/lo_we_i SHALL write wdata_i to HI/LO on the edge when the state is IDLE or DONE, and SHALL be ignored when busy_o=1.
REQ-034 hi_we_i and lo_we_i asserted together SHALL write both registers.
REQ-035 A write on the same edge as the DONE-entry update SHALL lose to the operation result.
REQ-036 A write together with an accepted start SHALL take effect, and the later completion SHALL overwrite it.
REQ-037 A start accepted in DONE SHALL begin a new operation back-to-back with no IDLE cycle, and done_o SHALL still pulse once per operation.

Reset
REQ-038 When rst_i=1 at an edge, in any state including mid-RUN, the block SHALL set: state IDLE, counter 0, busy_o=0, done_o=0, div_zero_o=0, hi_o=0, lo_o=0.
REQ-039 Reset SHALL discard any in-flight operation without producing a done_o pulse.
REQ-040 rst_i SHALL have priority over start_i and over the write enables.

Verification
REQ-041 MULT: src1=7, src2=0xFFFFFFFD -> done_o on the 33rd cycle after acceptance, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB, busy_o=1 for exactly 33 cycles.
REQ-042 MULTU: 0xFFFFFFFF x 0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001. DIV: 0xFFFFFFF9 / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
REQ-043 DIVU: 100 / 0 -> done_o in the cycle after acceptance, div_zero_o=1, lo_o=0xFFFFFFFF, hi_o=0x00000064, busy_o never 1.
REQ-044 DIV: 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0. Back-to-back: a second start asserted in DONE -> a second done_o pulse exactly 33 cycles later.
REQ-045 Reset mid-op: rst_i=1 for one edge at RUN iteration 10 -> next cycle busy_o=0, hi_o=lo_o=0, and no done_o within the next 40 cycles.
REQ-046 Writes: hi_we_i=1 with wdata=0x12345678 during RUN -> HI unchanged; the same write in IDLE -> hi_o=0x12345678 on the next cycle.
